iob_cache_read_arbiter_axi: RTL and testbench

- Shares one AXI line-fill read channel (`replace_valid`/`replace`/`read_*` interface) between N_REQ cache requesters, e.g. an I-cache and a D-cache on one back-end port.
- Arbitration is round-robin. The block holds the grant for a whole line fill, tracking the channel's `replace` busy flag, and steers returned beats only to the granted requester.

---
 rtl/iob_cache_read_arbiter_axi_pkg.sv | 34 +++
 rtl/iob_cache_rr_arbiter.sv | 42 ++++
 rtl/iob_cache_read_arbiter_axi.sv | 124 ++++++++++++
 tb/tb_iob_cache_read_arbiter_axi.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_read_arbiter_axi_pkg.sv
// Shared FSM encoding, reset defaults and one-hot/index helpers for the
// cache line-fill read arbiter.
package iob_cache_read_arbiter_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE
    } arb_state_e;

    localparam logic [3:0] CACHE_AXI_CACHE_MODE_DEFAULT = 4'b0011;

    // Upper bound on requesters the helpers below can encode.
    localparam int MAX_REQ = 32;

    // ORing the indices of set bits yields the index of a one-hot vector (0 if empty).
    function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input int idx);
        return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/iob_cache_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1,
// wrapping, and returns the first requesting index.
module iob_cache_rr_arbiter
    import iob_cache_read_arbiter_axi_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int REQ_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [REQ_W-1:0] last_grant_i,
    output logic [REQ_W-1:0] grant_o,
    output logic             any_req_o
);

    logic [REQ_W:0]   shift_amt;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] first_oh;
    logic [N_REQ-1:0] grant_oh;
    logic             found;

    // Rotate so the search start (last_grant+1) lands on bit 0.
    assign shift_amt = {1'b0, last_grant_i} + (REQ_W+1)'(1);
    assign rot       = N_REQ'({req_i, req_i} >> shift_amt);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        first_oh = '0;
        found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                first_oh[k] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Rotate the winner back into requester numbering.
    assign grant_oh  = N_REQ'(({first_oh, first_oh} << shift_amt) >> N_REQ);
    assign grant_o   = REQ_W'(onehot_to_idx(MAX_REQ'(grant_oh)));
    assign any_req_o = |req_i;

endmodule

// File: rtl/iob_cache_read_arbiter_axi.sv
// Shares one AXI line-fill read channel between N_REQ cache requesters;
// the grant is held for a whole fill and returned beats go only to the owner.
module iob_cache_read_arbiter_axi
    import iob_cache_read_arbiter_axi_pkg::*;
#(
    parameter int         N_REQ                = 2,
    parameter int         REQ_W                = $clog2(N_REQ),
    parameter int         LINE_ADDR_W          = 26,
    parameter int         LINE2BE_W            = 2,
    parameter int         BE_DATA_W            = 256,
    parameter logic [3:0] CACHE_AXI_CACHE_MODE = CACHE_AXI_CACHE_MODE_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ*LINE_ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*4-1:0]           req_acache_i,
    output logic [N_REQ-1:0]             req_ack_o,
    output logic [N_REQ-1:0]             req_done_o,
    output logic [N_REQ-1:0]             req_read_valid_o,
    output logic [LINE2BE_W-1:0]         req_read_addr_o,
    output logic [BE_DATA_W-1:0]         req_read_rdata_o,
    output logic                         replace_valid_o,
    output logic [LINE_ADDR_W-1:0]       replace_addr_o,
    output logic [3:0]                   replace_acache_o,
    input  logic                         replace_i,
    input  logic                         read_valid_i,
    input  logic [LINE2BE_W-1:0]         read_addr_i,
    input  logic [BE_DATA_W-1:0]         read_rdata_i
);

    arb_state_e             state_q;
    logic [REQ_W-1:0]       grant_q;
    logic [REQ_W-1:0]       last_grant_q;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [3:0]             acache_q;
    logic                   replace_valid_q;
    logic [N_REQ-1:0]       done_q;

    logic [REQ_W-1:0]       pick;
    logic                   any_req;
    logic                   in_fill;
    logic [LINE_ADDR_W-1:0] addr_arr   [N_REQ];
    logic [3:0]             acache_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i]   = req_addr_i[i*LINE_ADDR_W +: LINE_ADDR_W];
        assign acache_arr[i] = req_acache_i[i*4 +: 4];
    end

    iob_cache_rr_arbiter #(
        .N_REQ (N_REQ),
        .REQ_W (REQ_W)
    ) u_rr_arbiter (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .any_req_o    (any_req)
    );

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            last_grant_q    <= REQ_W'(N_REQ - 1);
            addr_q          <= '0;
            acache_q        <= CACHE_AXI_CACHE_MODE;
            replace_valid_q <= 1'b0;
            done_q          <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q         <= pick;
                        addr_q          <= addr_arr[pick];
                        acache_q        <= acache_arr[pick];
                        replace_valid_q <= 1'b1;
                        state_q         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    replace_valid_q <= 1'b0;
                    state_q         <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (replace_i) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // A slave-error replay keeps replace high, so the grant simply persists.
                    if (!replace_i) begin
                        done_q  <= N_REQ'(idx_to_onehot(int'(grant_q)));
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q       <= '0;
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_fill = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);

    assign req_ack_o        = (state_q == ST_IDLE && any_req)
                              ? N_REQ'(idx_to_onehot(int'(pick))) : '0;
    assign req_done_o       = done_q;
    assign req_read_valid_o = (read_valid_i && in_fill)
                              ? N_REQ'(idx_to_onehot(int'(grant_q))) : '0;
    assign req_read_addr_o  = read_addr_i;
    assign req_read_rdata_o = read_rdata_i;

    assign replace_valid_o  = replace_valid_q;
    assign replace_addr_o   = addr_q;
    assign replace_acache_o = acache_q;

endmodule

// File: tb/tb_iob_cache_read_arbiter_axi.sv
// Self-checking bench: requester and channel models drive the arbiter and a
// transaction-level reference predicts every output each cycle.
module tb_iob_cache_read_arbiter_axi;

    localparam int N_REQ       = 2;
    localparam int LINE_ADDR_W = 26;
    localparam int LINE2BE_W   = 2;
    localparam int BE_DATA_W   = 256;
    localparam int BEATS       = 1 << LINE2BE_W;

    logic                         clk_i = 1'b0;
    logic                         reset_i;
    logic [N_REQ-1:0]             req_valid_i;
    logic [N_REQ*LINE_ADDR_W-1:0] req_addr_i;
    logic [N_REQ*4-1:0]           req_acache_i;
    logic [N_REQ-1:0]             req_ack_o;
    logic [N_REQ-1:0]             req_done_o;
    logic [N_REQ-1:0]             req_read_valid_o;
    logic [LINE2BE_W-1:0]         req_read_addr_o;
    logic [BE_DATA_W-1:0]         req_read_rdata_o;
    logic                         replace_valid_o;
    logic [LINE_ADDR_W-1:0]       replace_addr_o;
    logic [3:0]                   replace_acache_o;
    logic                         replace_i;
    logic                         read_valid_i;
    logic [LINE2BE_W-1:0]         read_addr_i;
    logic [BE_DATA_W-1:0]         read_rdata_i;

    always #5 clk_i = ~clk_i;

    iob_cache_read_arbiter_axi #(
        .N_REQ (N_REQ)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .req_valid_i      (req_valid_i),
        .req_addr_i       (req_addr_i),
        .req_acache_i     (req_acache_i),
        .req_ack_o        (req_ack_o),
        .req_done_o       (req_done_o),
        .req_read_valid_o (req_read_valid_o),
        .req_read_addr_o  (req_read_addr_o),
        .req_read_rdata_o (req_read_rdata_o),
        .replace_valid_o  (replace_valid_o),
        .replace_addr_o   (replace_addr_o),
        .replace_acache_o (replace_acache_o),
        .replace_i        (replace_i),
        .read_valid_i     (read_valid_i),
        .read_addr_i      (read_addr_i),
        .read_rdata_i     (read_rdata_i)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Requesters: 0 idle, 1 valid held until ack, 2 waiting for done.
    int                     req_st     [N_REQ];
    int                     want       [N_REQ];
    logic [LINE_ADDR_W-1:0] nxt_addr   [N_REQ];
    logic [3:0]             nxt_acache [N_REQ];
    logic [LINE_ADDR_W-1:0] cur_addr   [N_REQ];
    logic [3:0]             cur_acache [N_REQ];
    int                     beat_cnt   [N_REQ];
    int                     done_cnt   [N_REQ];
    int                     grant_log  [$];

    // Channel model: ch_c counts cycles since it accepted replace_valid.
    int ch_c, ch_len;
    bit ch_retry, ch_fall, retry_next, stray_en;

    // Reference model of the arbiter at transaction level.
    bit                     m_free, m_issue, m_done_due;
    int                     m_last, m_owner;
    logic [LINE_ADDR_W-1:0] m_addr;
    logic [3:0]             m_acache;

    task automatic check(input string tag, input logic [BE_DATA_W-1:0] obs,
                         input logic [BE_DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int log_at(input int i);
        return (grant_log.size() > i) ? grant_log[i] : -1;
    endfunction

    function automatic bit quiet();
        bit q;
        q = m_free && !m_issue && !m_done_due && (ch_c == 0) && !ch_fall;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_st[i] != 0 || want[i] != 0) q = 1'b0;
        end
        return q;
    endfunction

    task automatic model_reset();
        m_free     = 1'b1;
        m_issue    = 1'b0;
        m_done_due = 1'b0;
        m_last     = N_REQ - 1;
        m_owner    = 0;
        m_addr     = '0;
        m_acache   = 4'b0011;
        ch_c       = 0;
        ch_fall    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_st[i] = 0;
            want[i]   = 0;
        end
    endtask

    task automatic clear_stats();
        grant_log.delete();
        for (int i = 0; i < N_REQ; i++) begin
            beat_cnt[i] = 0;
            done_cnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i      = 1'b1;
        req_valid_i  = '0;
        replace_i    = 1'b0;
        read_valid_i = 1'b0;
        model_reset();
    endtask

    // One clock: drive at negedge, sample 1 time unit later, then advance models.
    task automatic cycle();
        logic [N_REQ-1:0] exp_ack, exp_rdv, exp_done;
        bit beat_now;
        int bidx, g, j;

        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_st[i] == 0 && want[i] > 0) begin
                want[i]--;
                req_st[i]     = 1;
                cur_addr[i]   = nxt_addr[i];
                cur_acache[i] = nxt_acache[i];
            end
            req_valid_i[i] = (req_st[i] == 1);
            req_addr_i[i*LINE_ADDR_W +: LINE_ADDR_W] = (req_st[i] == 1) ? cur_addr[i] : ~cur_addr[i];
            req_acache_i[i*4 +: 4] = (req_st[i] == 1) ? cur_acache[i] : ~cur_acache[i];
        end

        beat_now = 1'b0;
        bidx     = 0;
        if (ch_c > 0) begin
            if (ch_c >= 2 && ch_c <= 1 + BEATS) begin
                beat_now = 1'b1;
                bidx     = ch_c - 2;
            end else if (ch_retry && ch_c >= 3 + BEATS) begin
                beat_now = 1'b1;
                bidx     = ch_c - 3 - BEATS;
            end
        end
        replace_i    = (ch_c > 0);
        read_valid_i = beat_now;
        read_addr_i  = LINE2BE_W'(bidx);
        for (int k = 0; k < BE_DATA_W / 32; k++) read_rdata_i[k*32 +: 32] = $urandom;
        if (!beat_now && ch_c == 0 && !ch_fall && stray_en && $urandom_range(3) == 0) begin
            read_valid_i = 1'b1;
            read_addr_i  = LINE2BE_W'($urandom);
        end

        #1;
        g = -1;
        exp_ack = '0;
        if (m_free && (|req_valid_i)) begin
            for (int k = 1; k <= N_REQ; k++) begin
                j = (m_last + k) % N_REQ;
                if (g < 0 && ((req_valid_i >> j) & N_REQ'(1)) != '0) g = j;
            end
            exp_ack = N_REQ'(1) << g;
        end
        exp_rdv  = beat_now ? (N_REQ'(1) << m_owner) : '0;
        exp_done = m_done_due ? (N_REQ'(1) << m_owner) : '0;

        check("ack", BE_DATA_W'(req_ack_o), BE_DATA_W'(exp_ack));
        check("replace_valid", BE_DATA_W'(replace_valid_o), BE_DATA_W'(m_issue));
        check("replace_addr", BE_DATA_W'(replace_addr_o), BE_DATA_W'(m_addr));
        check("replace_acache", BE_DATA_W'(replace_acache_o), BE_DATA_W'(m_acache));
        check("read_valid", BE_DATA_W'(req_read_valid_o), BE_DATA_W'(exp_rdv));
        check("done", BE_DATA_W'(req_done_o), BE_DATA_W'(exp_done));
        check("read_addr", BE_DATA_W'(req_read_addr_o), BE_DATA_W'(read_addr_i));
        check("read_rdata", req_read_rdata_o, read_rdata_i);

        for (int i = 0; i < N_REQ; i++) begin
            if (req_read_valid_o[i]) beat_cnt[i]++;
            if (req_done_o[i]) done_cnt[i]++;
        end

        m_issue = 1'b0;
        if (exp_done != '0) begin
            m_last = m_owner;
            m_free = 1'b1;
        end
        m_done_due = ch_fall;
        ch_fall    = 1'b0;
        if (g >= 0) begin
            m_free   = 1'b0;
            m_owner  = g;
            m_addr   = cur_addr[g];
            m_acache = cur_acache[g];
            m_issue  = 1'b1;
            grant_log.push_back(g);
        end

        if (ch_c > 0) begin
            ch_c++;
            if (ch_c > ch_len) begin
                ch_c    = 0;
                ch_fall = 1'b1;
            end
        end else if (replace_valid_o) begin
            ch_c       = 1;
            ch_retry   = retry_next;
            ch_len     = retry_next ? 2 + 2 * BEATS : 1 + BEATS;
            retry_next = 1'b0;
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (req_st[i] == 1 && req_ack_o[i]) req_st[i] = 2;
            else if (req_st[i] == 2 && req_done_o[i]) req_st[i] = 0;
        end
    endtask

    task automatic run_until_idle(input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!quiet() && n < 400);
        check(tag, BE_DATA_W'(quiet()), BE_DATA_W'(1));
    endtask

    initial begin
        reset_i      = 1'b1;
        req_valid_i  = '0;
        req_addr_i   = '0;
        req_acache_i = '0;
        replace_i    = 1'b0;
        read_valid_i = 1'b0;
        read_addr_i  = '0;
        read_rdata_i = '0;
        stray_en     = 1'b0;
        retry_next   = 1'b0;
        ch_retry     = 1'b0;
        ch_len       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cur_addr[i]   = '0;
            cur_acache[i] = '0;
            nxt_addr[i]   = '0;
            nxt_acache[i] = '0;
        end
        model_reset();
        clear_stats();

        // Reset state, acache default before any grant.
        do_reset();
        cycle();
        check("reset_acache", BE_DATA_W'(replace_acache_o), BE_DATA_W'(4'b0011));
        check("reset_addr", BE_DATA_W'(replace_addr_o), '0);

        // Single request from requester 0.
        clear_stats();
        nxt_addr[0]   = 26'h123;
        nxt_acache[0] = 4'($urandom);
        want[0]       = 1;
        run_until_idle("single_idle");
        check("single_beats0", BE_DATA_W'(beat_cnt[0]), BE_DATA_W'(BEATS));
        check("single_beats1", BE_DATA_W'(beat_cnt[1]), '0);
        check("single_done0", BE_DATA_W'(done_cnt[0]), BE_DATA_W'(1));
        check("single_grant", BE_DATA_W'(log_at(0)), '0);

        // Simultaneous requests after reset: requester 0 first.
        do_reset();
        clear_stats();
        nxt_addr[0] = 26'($urandom);
        nxt_addr[1] = 26'($urandom);
        want[0]     = 1;
        want[1]     = 1;
        run_until_idle("simul_idle");
        check("simul_first", BE_DATA_W'(log_at(0)), BE_DATA_W'(0));
        check("simul_second", BE_DATA_W'(log_at(1)), BE_DATA_W'(1));

        // Fairness: requester 0 re-requests right after each done.
        do_reset();
        clear_stats();
        want[0] = 2;
        want[1] = 2;
        run_until_idle("fair_idle");
        check("fair_g0", BE_DATA_W'(log_at(0)), BE_DATA_W'(0));
        check("fair_g1", BE_DATA_W'(log_at(1)), BE_DATA_W'(1));
        check("fair_g2", BE_DATA_W'(log_at(2)), BE_DATA_W'(0));
        check("fair_g3", BE_DATA_W'(log_at(3)), BE_DATA_W'(1));

        // Acache latch: input flips to 4'h0 after ack, output must keep 4'hF.
        clear_stats();
        nxt_acache[0] = 4'hF;
        want[0]       = 1;
        run_until_idle("acache_idle");
        repeat (3) cycle();
        check("acache_held", BE_DATA_W'(replace_acache_o), BE_DATA_W'(4'hF));

        // Slave-error replay: 8 beats, one done.
        clear_stats();
        retry_next = 1'b1;
        want[1]    = 1;
        run_until_idle("retry_idle");
        check("retry_beats1", BE_DATA_W'(beat_cnt[1]), BE_DATA_W'(2 * BEATS));
        check("retry_beats0", BE_DATA_W'(beat_cnt[0]), '0);
        check("retry_done1", BE_DATA_W'(done_cnt[1]), BE_DATA_W'(1));

        // Mid-fill reset during WAIT_DONE: no done pulse, then requester 0 wins.
        clear_stats();
        want[0] = 1;
        for (int n = 0; n < 50 && ch_c < 3; n++) cycle();
        check("midrst_reached", BE_DATA_W'(ch_c >= 3), BE_DATA_W'(1));
        do_reset();
        repeat (4) cycle();
        check("midrst_nodone", BE_DATA_W'(done_cnt[0]), '0);
        clear_stats();
        want[1] = 1;
        want[0] = 1;
        run_until_idle("midrst_idle");
        check("midrst_first", BE_DATA_W'(log_at(0)), BE_DATA_W'(0));

        // Randomized traffic with stray beats outside fills.
        stray_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_st[i] == 0 && want[i] == 0 && $urandom_range(1) == 1) begin
                    nxt_addr[i]   = 26'($urandom);
                    nxt_acache[i] = 4'($urandom);
                    want[i]       = 1 + int'($urandom_range(1));
                end
            end
            if ($urandom_range(4) == 0) retry_next = 1'b1;
            repeat (1 + $urandom_range(14)) cycle();
        end
        run_until_idle("random_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
